// File: rtl/xocc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// xocc_pkg : opcodes, FSM state codes and flag positions shared by
//            the xocc command encoder and decoder.
// Rev 1.0
// ------------------------------------------------------------------
package xocc_pkg;

  localparam logic [5:0] c_OP_WEIGHT       = 6'b000100;
  localparam logic [5:0] c_OP_ATTR         = 6'b000101;
  localparam logic [5:0] c_OP_BIAS         = 6'b000110;
  localparam logic       c_OP_START_PREFIX = 1'b1;

  // job_flags = {silent, bias, relu, clear, partial}
  localparam int c_FLAG_W      = 5;
  localparam int c_FLAG_BIAS   = 3;
  localparam int c_FLAG_SILENT = 4;

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_WEIGHT   = 3'd1;
  localparam logic [2:0] c_ST_ATTR     = 3'd2;
  localparam logic [2:0] c_ST_BIAS     = 3'd3;
  localparam logic [2:0] c_ST_START    = 3'd4;
  localparam logic [2:0] c_ST_WAIT_RSP = 3'd5;

  function automatic logic [5:0] start_opcode(input logic [c_FLAG_W-1:0] flags);
    return {c_OP_START_PREFIX, flags};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xocc_timeout_cnt.sv
`default_nettype none
// ------------------------------------------------------------------
// xocc_timeout_cnt : response timeout counter; expired when all-ones.
// Rev 1.0
// ------------------------------------------------------------------
module xocc_timeout_cnt #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_expired = &r_count;

endmodule
`default_nettype wire

// File: rtl/xocc_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// xocc_encoder : turns a job descriptor into WEIGHT/ATTR/[BIAS]/START
//                commands and optionally waits for one response.
// Rev 1.0
// ------------------------------------------------------------------
module xocc_encoder
  import xocc_pkg::*;
#(
  parameter int CMD_WORD_WIDTH   = 32,
  parameter int CMD_WORD_NUM     = 3,
  parameter int RSP_WORD_NUM     = 1,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int BLOCK_SIZE_WIDTH = 6,
  parameter int TIMEOUT_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   job_valid,
  output logic                                   job_ready,
  input  logic [ADDRESS_WIDTH-1:0]               job_weight_addr,
  input  logic [ADDRESS_WIDTH-1:0]               job_attr_addr,
  input  logic [ADDRESS_WIDTH-1:0]               job_bias_addr,
  input  logic [ADDRESS_WIDTH-1:0]               job_acc_addr,
  input  logic [BLOCK_SIZE_WIDTH-1:0]            job_block_size,
  input  logic [4:0]                             job_flags,
  input  logic                                   cmd_fifo_full,
  output logic                                   cmd_fifo_wr_en,
  output logic [CMD_WORD_NUM*CMD_WORD_WIDTH-1:0] cmd_o,
  input  logic                                   rsp_fifo_empty,
  output logic                                   rsp_fifo_rd_en,
  input  logic [RSP_WORD_NUM*CMD_WORD_WIDTH-1:0] rsp_i,
  output logic                                   busy,
  output logic                                   job_done,
  output logic                                   rsp_error,
  output logic                                   rsp_timeout,
  output logic [15:0]                            jobs_completed
);

  localparam int c_CMD_W = CMD_WORD_NUM * CMD_WORD_WIDTH;
  localparam int c_RSP_W = RSP_WORD_NUM * CMD_WORD_WIDTH;

  logic [2:0]                  r_state;
  logic [ADDRESS_WIDTH-1:0]    r_weight_addr;
  logic [ADDRESS_WIDTH-1:0]    r_attr_addr;
  logic [ADDRESS_WIDTH-1:0]    r_bias_addr;
  logic [ADDRESS_WIDTH-1:0]    r_acc_addr;
  logic [BLOCK_SIZE_WIDTH-1:0] r_block_size;
  logic [c_FLAG_W-1:0]         r_flags;
  logic                        r_job_done;
  logic                        r_rsp_error;
  logic                        r_rsp_timeout;
  logic [15:0]                 r_jobs_completed;

  logic                        w_cmd_state;
  logic                        w_in_wait;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_rsp_ok;
  logic                        w_done_set;
  logic                        w_tmo_expired;
  logic [5:0]                  w_opcode;
  logic [BLOCK_SIZE_WIDTH-1:0] w_block;
  logic [ADDRESS_WIDTH-1:0]    w_addr;

  assign w_cmd_state = (r_state == c_ST_WEIGHT) || (r_state == c_ST_ATTR) ||
                       (r_state == c_ST_BIAS)   || (r_state == c_ST_START);
  assign w_in_wait   = (r_state == c_ST_WAIT_RSP);
  assign w_push      = w_cmd_state & ~cmd_fifo_full;
  assign w_pop       = w_in_wait & ~rsp_fifo_empty;
  assign w_rsp_ok    = (rsp_i == c_RSP_W'(1));
  assign w_done_set  = ((r_state == c_ST_START) & w_push & r_flags[c_FLAG_SILENT]) | w_pop;

  xocc_timeout_cnt #(
    .WIDTH(TIMEOUT_WIDTH)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (~w_in_wait),
    .i_enable (w_in_wait & ~w_pop),
    .o_expired(w_tmo_expired)
  );

  always_comb begin
    w_opcode = '0;
    w_block  = '0;
    w_addr   = '0;
    case (r_state)
      c_ST_WEIGHT: begin w_opcode = c_OP_WEIGHT; w_addr = r_weight_addr; end
      c_ST_ATTR:   begin w_opcode = c_OP_ATTR;   w_addr = r_attr_addr;   end
      c_ST_BIAS:   begin w_opcode = c_OP_BIAS;   w_addr = r_bias_addr;   end
      c_ST_START: begin
        w_opcode = start_opcode(r_flags);
        w_block  = r_block_size;
        w_addr   = r_acc_addr;
      end
      default: ;
    endcase
    cmd_o = '0;
    cmd_o[5:0]                                 = w_opcode;
    cmd_o[CMD_WORD_WIDTH +: BLOCK_SIZE_WIDTH]  = w_block;
    cmd_o[2*CMD_WORD_WIDTH +: ADDRESS_WIDTH]   = w_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= c_ST_IDLE;
      r_weight_addr    <= '0;
      r_attr_addr      <= '0;
      r_bias_addr      <= '0;
      r_acc_addr       <= '0;
      r_block_size     <= '0;
      r_flags          <= '0;
      r_job_done       <= 1'b0;
      r_rsp_error      <= 1'b0;
      r_rsp_timeout    <= 1'b0;
      r_jobs_completed <= '0;
    end else begin
      r_job_done <= w_done_set;
      if (w_done_set) begin
        r_jobs_completed <= r_jobs_completed + 16'd1;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (job_valid) begin
            r_weight_addr <= job_weight_addr;
            r_attr_addr   <= job_attr_addr;
            r_bias_addr   <= job_bias_addr;
            r_acc_addr    <= job_acc_addr;
            r_block_size  <= job_block_size;
            r_flags       <= job_flags;
            r_state       <= c_ST_WEIGHT;
          end
        end
        c_ST_WEIGHT: if (w_push) r_state <= c_ST_ATTR;
        c_ST_ATTR:   if (w_push) r_state <= r_flags[c_FLAG_BIAS] ? c_ST_BIAS : c_ST_START;
        c_ST_BIAS:   if (w_push) r_state <= c_ST_START;
        c_ST_START: begin
          if (w_push) begin
            r_state <= r_flags[c_FLAG_SILENT] ? c_ST_IDLE : c_ST_WAIT_RSP;
          end
        end
        c_ST_WAIT_RSP: begin
          // A pop in the same cycle the counter saturates wins over timeout.
          if (w_pop) begin
            r_state <= c_ST_IDLE;
            if (!w_rsp_ok) r_rsp_error <= 1'b1;
          end else if (w_tmo_expired) begin
            r_state       <= c_ST_IDLE;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign job_ready      = (r_state == c_ST_IDLE);
  assign busy           = (r_state != c_ST_IDLE);
  assign cmd_fifo_wr_en = w_push;
  assign rsp_fifo_rd_en = w_pop;
  assign job_done       = r_job_done;
  assign rsp_error      = r_rsp_error;
  assign rsp_timeout    = r_rsp_timeout;
  assign jobs_completed = r_jobs_completed;

endmodule
`default_nettype wire

// File: doc/xocc_encoder.md
XOCC_ENCODER -- requirements
Module: xocc_encoder

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- CMD_WORD_WIDTH, 32, command word width
- CMD_WORD_NUM, 3, words per command
- RSP_WORD_NUM, 1, words per response
- ADDRESS_WIDTH, 32, address width
- BLOCK_SIZE_WIDTH, 6, block_size width
- TIMEOUT_WIDTH, 16, response timeout counter width
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- reset_n  in  1  reset
- job_valid  in  1  job descriptor offered
- job_ready  out  1  descriptor accepted this cycle when job_valid & job_ready
- job_weight_addr, job_attr_addr, job_bias_addr, job_acc_addr  in  ADDRESS_WIDTH each  operand addresses
- job_block_size  in  BLOCK_SIZE_WIDTH  block size
- job_flags  in  5  {silent,bias,relu,clear,partial}
- cmd_fifo_full  in  1  command FIFO full
- cmd_fifo_wr_en  out  1  command push strobe
- cmd_o  out  CMD_WORD_NUM*CMD_WORD_WIDTH  command
- rsp_fifo_empty  in  1  response FIFO empty (show-ahead)
- rsp_fifo_rd_en  out  1  response pop strobe
- rsp_i  in  RSP_WORD_NUM*CMD_WORD_WIDTH  response head word
- busy  out  1  state != IDLE
- job_done  out  1  one-cycle completion pulse
- rsp_error  out  1  sticky: response value != 1
- rsp_timeout  out  1  sticky: no response within limit
- jobs_completed  out  16  completed-job counter
REQ-003 SHALL use one clock; reset is asynchronous and active-low (clk, reset_n).

Function
REQ-004 SHALL implement states IDLE, WEIGHT, ATTR, BIAS, START, WAIT_RSP.
REQ-005 job_ready SHALL be 1 only in IDLE; on acceptance SHALL register all job_* fields and go to WEIGHT next cycle.
REQ-006 Command encoding: word0[5:0] opcode, other bits 0; word1[BLOCK_SIZE_WIDTH-1:0] block size (START only, else 0); word2[ADDRESS_WIDTH-1:0] address.
REQ-007 Opcodes: WEIGHT 6'b000100 (weight addr), ATTR 6'b000101 (attr addr), BIAS 6'b000110 (bias addr), START {1'b1,silent,bias,relu,clear,partial} (acc addr).
REQ-008 In each command state, cmd_fifo_wr_en SHALL equal ~cmd_fifo_full (combinational); cmd_o SHALL be valid whole state; state advances only on a push cycle.
REQ-009 Sequence: WEIGHT -> ATTR -> BIAS (only if bias flag=1, else skipped) -> START; exactly one push per state.
REQ-010 After START push: silent=1 -> IDLE with job_done pulse; silent=0 -> WAIT_RSP with timeout counter cleared.
REQ-011 In WAIT_RSP, rsp_fifo_rd_en SHALL equal ~rsp_fifo_empty; on pop, rsp_i==1 -> IDLE + job_done; other value -> IDLE + job_done + rsp_error set.
REQ-012 Timeout counter SHALL increment each WAIT_RSP cycle without pop; at all-ones -> IDLE, rsp_timeout set, no job_done; pop in same cycle as all-ones takes priority over timeout.
REQ-013 jobs_completed SHALL increment on every job_done, wrapping 16'hFFFF -> 0.
REQ-014 rsp_error/rsp_timeout SHALL stay set until reset; they SHALL not block further jobs.
REQ-015 rsp_fifo_rd_en SHALL be 0 outside WAIT_RSP; responses arriving then are left in the FIFO.
REQ-016 cmd_fifo_wr_en SHALL be 0 in IDLE and WAIT_RSP.

Reset
REQ-017 reset_n low SHALL asynchronously force IDLE, all registered job fields, counters and sticky flags to 0; job_ready=1, all strobes 0, cmd_o=0.
REQ-018 Reset mid-sequence SHALL abandon the job; no further pushes/pops until a new job is accepted.

Structure
REQ-019 Opcode localparams (000100, 000101, 000110, START prefix 1'b1) and state enum SHALL live in a shared xocc_pkg also used by the decoder.
REQ-020 Timeout counter SHALL be a sub-module xocc_timeout_cnt (clear, enable, expired).
REQ-021 Single always_ff for state/registers; strobes combinational from state and FIFO flags.

Verification
REQ-022 Job flags=5'b01000, addrs W=0x1000 A=0x2000 B=0x3000 C=0x4000, block 16, FIFO never full -> 4 pushes on consecutive cycles: opcodes 04,05,06,0x28; START word1=16, word2=0x4000; then rsp 1 -> job_done, jobs_completed=1.
REQ-023 Flags=5'b00110 -> 3 pushes (no BIAS), START opcode 0x26.
REQ-024 cmd_fifo_full held 5 cycles during ATTR -> no push, cmd_o stable, ATTR pushed on first cycle full=0.
REQ-025 Silent flags=5'b10000 -> IDLE right after START push, job_done, rsp_fifo_rd_en never 1.
REQ-026 TIMEOUT_WIDTH=4, no response -> rsp_timeout after 15 cycles in WAIT_RSP, no job_done; response value 2 on next job -> rsp_error=1.
REQ-027 reset_n low during BIAS -> outputs at reset values immediately; next job restarts at WEIGHT.
